riscv_lsu: RTL
==============

# riscv_lsu

Load/store unit for the memory stage of the pipelined RV32I core. It consumes the memory-stage control and data fields (load/store flags, byte-lane select, ALU address, store data, func3) and runs a req/ack transaction on the data bus. It stalls the pipeline until the transaction completes and returns aligned, sign- or zero-extended load data to the writeback path. Misaligned accesses are trapped before reaching the bus, and stuck accesses are caught by a bus timeout.

## Interface
- BUS_TIMEOUT, 255: cycles in REQ without i_dbus_ack before the access is aborted with an error (1..255).
- REGISTER_INIT, 0: reset value of all registered outputs.
- i_clk  in  1  clock; reset i_rstn, asynchronous, active-low.
- i_rstn  in  1  asynchronous active-low reset.
- i_lsu_is_load  in  1  memory-stage instruction is a load.
- i_lsu_mem_wr_en  in  1  memory-stage instruction is a store.
- i_lsu_mem_byte_sel  in  4  lane enables, already positioned by addr[1:0] (SB@2 → 4'b0100).
- i_lsu_addr  in  XLEN  byte address (ALU result).
- i_lsu_wr_data  in  XLEN  unshifted store data (rs2).
- i_lsu_func3  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- o_lsu_stall  out  1  hold the preceding pipeline registers (drives their enables low).
- o_lsu_rd_data  out  XLEN  formatted load data.
- o_lsu_rd_valid  out  1  one-cycle pulse; o_lsu_rd_data valid.
- o_lsu_misaligned  out  1  one-cycle pulse; access trapped, no bus cycle.
- o_lsu_bus_err  out  1  one-cycle pulse; access timed out.
- o_dbus_req  out  1  bus request, held until ack or timeout.
- o_dbus_we  out  1  1 = write.
- o_dbus_addr  out  XLEN  word address, {addr[XLEN-1:2], 2'b00}.
- o_dbus_wdata  out  XLEN  lane-replicated store data.
- o_dbus_be  out  4  byte enables (writes); 4'b1111 on reads.
- i_dbus_ack  in  1  transaction complete; i_dbus_rdata valid on reads.
- i_dbus_rdata  in  XLEN  read word.

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE**
  - Access = is_load | mem_wr_en. If both are set, the access is a load; the store is ignored.
  - Misalignment check:
    - H/HU/SH with addr[0] = 1 is misaligned.
    - W/SW with addr[1:0] ≠ 0 is misaligned.
    - A misaligned access pulses o_lsu_misaligned next cycle, stays in IDLE, and asserts no stall.
  - A valid access asserts o_lsu_stall combinationally in the same cycle. The LSU then captures the address, func3, offset, and formatted write data/byte enables, and moves to REQ.
- **REQ**
  - o_dbus_req = 1 with all bus outputs stable. o_lsu_stall = 1.
  - The timeout counter increments each cycle without i_dbus_ack.
  - On i_dbus_ack, go to DONE; for loads, the formatted rdata is registered into o_lsu_rd_data.
  - When the counter equals BUS_TIMEOUT, drop req and go to DONE with an error flag set; rd_data = 0.
- **DONE**
  - o_lsu_stall = 0, so the pipeline advances at the end of this cycle.
  - One of the following pulses this cycle: o_lsu_rd_valid (load), o_lsu_bus_err (timeout), or nothing (store).
  - Next state is IDLE unconditionally. The instruction still present at the inputs in DONE is not re-issued.
- **Store data:** B → {4{wd[7:0]}}, H → {2{wd[15:0]}}, W → wd.
- **Load format:**
  - B/BU: byte addr[1:0], sign/zero-extended.
  - H/HU: halfword selected by addr[1], sign/zero-extended.
  - W: full word.
  - Undefined func3 is treated as W.
- o_dbus_be equals i_lsu_mem_byte_sel for writes.

## Timing
- Reset value of every output is REGISTER_INIT (0); state IDLE; counter 0.
- Reset mid-transaction drops o_dbus_req immediately, with no completion pulse.
- Zero-wait access (ack in the first REQ cycle):
  - cycle T IDLE, stall = 1;
  - T+1 REQ, req = 1, ack = 1;
  - T+2 DONE, rd_valid = 1, stall = 0.
- Throughput: one access per 3 cycles minimum. Each wait cycle adds one.
- Back-to-back accesses: IDLE follows DONE, so a new access is first seen one cycle after DONE.
- Ack is sampled only in REQ; an ack in IDLE or DONE is ignored.
- Ack on the same edge as the counter reaching BUS_TIMEOUT: the ack wins, with no error.
- Non-memory instructions pass with stall = 0 and no pulses.

## Test plan
- **Zero-wait LW:** addr 0x104, ack in the first REQ cycle, rdata 0xDEADBEEF → req at T+1, rd_valid at T+2 with rd_data 0xDEADBEEF; stall high at T and T+1 only.
- **LB/LBU:** addr 0x203, rdata 0x80FF7F01 → LB gives 0xFFFFFF80 and LBU gives 0x00000080.
- **LH:** addr 0x202, rdata 0x80FF7F01 → 0xFFFF80FF.
- **SB:** addr 0x1002, wd 0x12345678, byte_sel 4'b0100, ack after 3 waits → dbus_addr 0x1000, wdata 0x78787878, be 4'b0100, we = 1; stall for 5 cycles; no rd_valid.
- **Misaligned LW:** addr 0x101 → misaligned pulse, req never asserted, stall never asserted.
- **Timeout:** BUS_TIMEOUT = 4 with ack held low → req drops after 4 REQ cycles, bus_err pulses in DONE, rd_data = 0. Separately, asserting rstn low mid-REQ clears req and all outputs to 0.

Source files
------------

// File: rtl/riscv_lsu.sv
// riscv_lsu: memory-stage load/store unit, req/ack data bus master.
// Ports: i_lsu_* from the pipeline, o_lsu_* to stall/writeback, *_dbus_* to the bus.
module riscv_lsu #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned BUS_TIMEOUT   = 255,
    parameter logic        REGISTER_INIT = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_lsu_is_load,
    input  logic            i_lsu_mem_wr_en,
    input  logic [3:0]      i_lsu_mem_byte_sel,
    input  logic [XLEN-1:0] i_lsu_addr,
    input  logic [XLEN-1:0] i_lsu_wr_data,
    input  logic [2:0]      i_lsu_func3,
    output logic            o_lsu_stall,
    output logic [XLEN-1:0] o_lsu_rd_data,
    output logic            o_lsu_rd_valid,
    output logic            o_lsu_misaligned,
    output logic            o_lsu_bus_err,
    output logic            o_dbus_req,
    output logic            o_dbus_we,
    output logic [XLEN-1:0] o_dbus_addr,
    output logic [XLEN-1:0] o_dbus_wdata,
    output logic [3:0]      o_dbus_be,
    input  logic            i_dbus_ack,
    input  logic [XLEN-1:0] i_dbus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      cnt;
    logic            load_q;
    logic [2:0]      func3_q;
    logic [1:0]      off_q;
    logic            access;
    logic            sz_h;
    logic            sz_w;
    logic            misal;
    logic            timeout;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic            sgn;
    logic [XLEN-1:0] ld_fmt;
    logic [XLEN-1:0] st_fmt;

    assign access  = i_lsu_is_load | i_lsu_mem_wr_en;
    // func3[1] set covers W and the undefined encodings, all treated as word
    assign sz_w    = i_lsu_func3[1];
    assign sz_h    = ~i_lsu_func3[1] & i_lsu_func3[0];
    assign misal   = (sz_h & i_lsu_addr[0]) | (sz_w & (|i_lsu_addr[1:0]));
    // the edge that would bring the count to BUS_TIMEOUT aborts instead
    assign timeout = (cnt == 8'(BUS_TIMEOUT - 1));

    always_comb begin
        st_fmt = i_lsu_wr_data;
        if (!i_lsu_func3[1]) begin
            if (i_lsu_func3[0]) st_fmt = {(XLEN/16){i_lsu_wr_data[15:0]}};
            else                st_fmt = {(XLEN/8){i_lsu_wr_data[7:0]}};
        end
    end

    always_comb begin
        byte_v = i_dbus_rdata[{off_q, 3'b000} +: 8];
        half_v = off_q[1] ? i_dbus_rdata[31:16] : i_dbus_rdata[15:0];
        sgn    = ~func3_q[2];
        ld_fmt = i_dbus_rdata;
        if (!func3_q[1]) begin
            if (func3_q[0]) ld_fmt = {{(XLEN-16){sgn & half_v[15]}}, half_v};
            else            ld_fmt = {{(XLEN-8){sgn & byte_v[7]}}, byte_v};
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (access && !misal) state_nxt = REQ;
            REQ:     if (i_dbus_ack || timeout) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_lsu_stall = 1'b0;
        o_dbus_req  = 1'b0;
        case (state)
            IDLE: o_lsu_stall = access & ~misal;
            REQ: begin
                o_lsu_stall = 1'b1;
                o_dbus_req  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt              <= '0;
            load_q           <= 1'b0;
            func3_q          <= '0;
            off_q            <= '0;
            o_lsu_rd_data    <= {XLEN{REGISTER_INIT}};
            o_lsu_rd_valid   <= REGISTER_INIT;
            o_lsu_misaligned <= REGISTER_INIT;
            o_lsu_bus_err    <= REGISTER_INIT;
            o_dbus_we        <= REGISTER_INIT;
            o_dbus_addr      <= {XLEN{REGISTER_INIT}};
            o_dbus_wdata     <= {XLEN{REGISTER_INIT}};
            o_dbus_be        <= {4{REGISTER_INIT}};
        end else begin
            o_lsu_rd_valid   <= 1'b0;
            o_lsu_misaligned <= 1'b0;
            o_lsu_bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (access && misal) begin
                        o_lsu_misaligned <= 1'b1;
                    end else if (access) begin
                        load_q       <= i_lsu_is_load;
                        func3_q      <= i_lsu_func3;
                        off_q        <= i_lsu_addr[1:0];
                        o_dbus_we    <= ~i_lsu_is_load;
                        o_dbus_addr  <= {i_lsu_addr[XLEN-1:2], 2'b00};
                        o_dbus_wdata <= st_fmt;
                        o_dbus_be    <= i_lsu_is_load ? 4'hF : i_lsu_mem_byte_sel;
                    end
                end
                REQ: begin
                    if (i_dbus_ack) begin
                        if (load_q) begin
                            o_lsu_rd_data  <= ld_fmt;
                            o_lsu_rd_valid <= 1'b1;
                        end
                    end else if (timeout) begin
                        o_lsu_bus_err <= 1'b1;
                        o_lsu_rd_data <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
